// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port, word-wide data RAM (combinational read, posedge
// write, no byte enables) between m0 (core load/store unit) and m1
// (debug/loader port). Arbitration is round-robin by default. Byte and
// halfword stores are done as read-modify-write: read the word, merge the
// enabled lanes, then write the merged word back.
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  - when defined, m0 always wins a tie and the
//                            round-robin history register is not built.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mN_req/we/addr/wdata/be   request from master N (N = 0, 1)
//   mN_gnt            combinational grant pulse, IDLE cycles only
//   mN_rvalid         one-cycle completion pulse (reads and writes)
//   mN_rdata          read data; held until the next read completion to
//                     that master, forced to 0 in a write's rvalid cycle
//   ram_we_o/addr_o/wdata_o   RAM write enable, word address, write data
//   ram_rdata_i       RAM combinational read data
//   dbg_state         current FSM state (0 IDLE, 1 ACCESS, 2 RMW_WR)
//
// Handshake: a master raises req with we/addr/wdata/be and holds them
// stable until it sees gnt high in a cycle; the request is accepted at the
// clock edge that ends that cycle. The master may drop req before gnt with
// no effect. Completion is signalled later by a single rvalid pulse; there
// is no backpressure on rvalid.

module ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t state_q, state_d;

  // Latched winning request
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;
  logic              lat_id;

  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rv0_q, rv1_q, rv_wr_q;

  logic win_valid, win_id, grant_en, done;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_valid = m0_req | m1_req;
    win_id    = ~m0_req;
  end
`else
  logic rr_last;

  // On a tie the master that did not win last time goes next.
  always_comb begin
    win_valid = m0_req | m1_req;
    win_id    = (m0_req && m1_req) ? ~rr_last : ~m0_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (grant_en) begin
      rr_last <= win_id;
    end
  end
`endif

  assign grant_en = (state_q == IDLE) && !rst && win_valid;
  assign m0_gnt   = grant_en && !win_id;
  assign m1_gnt   = grant_en && win_id;

  // Per-lane merge of the store data into the word read back from RAM.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : ram_rdata_i[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and RAM drive
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_en) state_d = ACCESS;
      end
      ACCESS: begin
        ram_addr_o = lat_addr;
        if (lat_we && lat_be == 4'hF) begin
          ram_we_o    = 1'b1;
          ram_wdata_o = lat_wdata;
        end
        if (lat_we && lat_be != 4'h0 && lat_be != 4'hF) begin
          state_d = RMW_WR;
        end else begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      RMW_WR: begin
        ram_we_o    = 1'b1;
        ram_addr_o  = lat_addr;
        ram_wdata_o = merge_q;
        state_d     = IDLE;
        done        = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Nothing reaches the RAM pins while reset is asserted.
    if (rst) begin
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_id    <= 1'b0;
      merge_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      rv_wr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rv0_q   <= done && !lat_id;
      rv1_q   <= done && lat_id;
      // Latched fields only change on a new grant, which is never in the
      // same cycle as done, so this is the completing transaction's type.
      rv_wr_q <= lat_we;
      if (grant_en) begin
        lat_id    <= win_id;
        lat_we    <= win_id ? m1_we : m0_we;
        lat_addr  <= (win_id ? m1_addr : m0_addr) & WORD_MASK;
        lat_wdata <= win_id ? m1_wdata : m0_wdata;
        lat_be    <= win_id ? m1_be : m0_be;
      end
      if (state_q == ACCESS) begin
        merge_q <= merged;
        if (!lat_we) begin
          if (lat_id) rdata1_q <= ram_rdata_i;
          else        rdata0_q <= ram_rdata_i;
        end
      end
    end
  end

  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign m0_rdata  = (rv0_q && rv_wr_q) ? '0 : rdata0_q;
  assign m1_rdata  = (rv1_q && rv_wr_q) ? '0 : rdata1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table of single transactions, hand-written
// multi-cycle sequences, then random two-master traffic checked against a
// transaction-level reference model.
module tb_ram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we_o;
  logic [31:0] m0_rdata, m1_rdata, ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic [1:0]  dbg_state;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i), .dbg_state(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [0:1023];
  logic        pre_we = 0;
  logic [9:0]  pre_idx = 0;
  logic [31:0] pre_data = 0;

  assign ram_rdata_i = mem[ram_addr_o[11:2]];
  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o[11:2]] <= ram_wdata_o;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_idx = byte_addr[11:2]; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we_o}, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr_o, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata_o, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  function automatic logic gnt_of(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction
  function automatic logic rv_of(input int m);
    return (m == 0) ? m0_rvalid : m1_rvalid;
  endfunction
  function automatic logic [31:0] rd_of(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  // One isolated transaction: grant cycle, completion cycle, returned data,
  // number of RAM write cycles, and RAM address one cycle after grant.
  task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int gc, output int rc, output logic [31:0] rd,
                         output int nwe, output logic [31:0] a1);
    gc = -1; rc = -1; rd = '0; nwe = 0; a1 = '0;
    @(posedge clk); #1;
    set_req(m, 1'b1, we, addr, wdata, be);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_of(m)) begin
        gc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    set_req(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    if (gc < 0) begin
      note_timeout("txn_gnt");
      return;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cyc == gc + 1) a1 = ram_addr_o;
      if (ram_we_o) nwe++;
      if (rv_of(m)) begin
        rc = cyc;
        rd = rd_of(m);
        break;
      end
    end
    if (rc < 0) note_timeout("txn_rvalid");
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // Region 0x800..0x83F (16 words) is used for random traffic.
  logic [31:0] ref_mem [0:15];
  logic [31:0] exp_q0[$], exp_q1[$];
  int          due_q0[$], due_q1[$];
  int          free_cyc = 0;
  int          last_win = 1;
  int          wc_pending = -1;
  logic [31:0] exp_wa = 0, exp_wd = 0;
  logic        gseen0 = 0, gseen1 = 0;
  logic        pend0 = 0, pend1 = 0;

  task automatic mon_cycle();
    int c, win, lat, idx;
    logic [1:0] exp_g;
    logic w;
    logic [31:0] a, d, nv;
    logic [3:0] b;
    c = cyc; exp_g = 2'b00; win = 0;
    gseen0 = 0; gseen1 = 0;
    // Arbiter is free once the previous transaction's completion cycle is reached.
    if (c >= free_cyc && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = 1 - last_win;
`endif
      end else begin
        win = m0_req ? 0 : 1;
      end
      exp_g = (win == 1) ? 2'b10 : 2'b01;
    end
    chk("arb_gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_g});
    chk("rnd_ram_we", {31'd0, ram_we_o}, {31'd0, (c == wc_pending)});
    if (c == wc_pending) begin
      chk("rnd_ram_addr", ram_addr_o, exp_wa);
      chk("rnd_ram_wdata", ram_wdata_o, exp_wd);
    end
    if (due_q0.size() > 0 && due_q0[0] == c) begin
      chk("rnd_rvalid0", {31'd0, m0_rvalid}, 32'd1);
      chk("rnd_rdata0", m0_rdata, exp_q0[0]);
      void'(due_q0.pop_front()); void'(exp_q0.pop_front());
    end else begin
      chk("rnd_rvalid0_idle", {31'd0, m0_rvalid}, 32'd0);
    end
    if (due_q1.size() > 0 && due_q1[0] == c) begin
      chk("rnd_rvalid1", {31'd0, m1_rvalid}, 32'd1);
      chk("rnd_rdata1", m1_rdata, exp_q1[0]);
      void'(due_q1.pop_front()); void'(exp_q1.pop_front());
    end else begin
      chk("rnd_rvalid1_idle", {31'd0, m1_rvalid}, 32'd0);
    end
    if (exp_g != 2'b00) begin
      w = win ? m1_we : m0_we;
      a = win ? m1_addr : m0_addr;
      d = win ? m1_wdata : m0_wdata;
      b = win ? m1_be : m0_be;
      idx = int'(a[5:2]);
      lat = 2;
      if (!w) begin
        nv = ref_mem[idx];
      end else begin
        ref_mem[idx] = merge_be(ref_mem[idx], d, b);
        nv = 32'd0;
        if (b == 4'hF) wc_pending = c + 1;
        else if (b != 4'h0) begin
          wc_pending = c + 2;
          lat = 3;
        end
        exp_wa = {a[31:2], 2'b00};
        exp_wd = ref_mem[idx];
      end
      if (win == 0) begin exp_q0.push_back(nv); due_q0.push_back(c + lat); gseen0 = 1; end
      else          begin exp_q1.push_back(nv); due_q1.push_back(c + lat); gseen1 = 1; end
      free_cyc = c + lat;
      last_win = win;
    end
  endtask

  task automatic drive_rand(input logic allow_new);
    for (int m = 0; m < 2; m++) begin
      logic p, g;
      p = (m == 0) ? pend0 : pend1;
      g = (m == 0) ? gseen0 : gseen1;
      if (g) begin
        p = 0;
        set_req(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end
      if (p && $urandom_range(0, 15) == 0) begin
        p = 0;
        set_req(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      end else if (!p && allow_new && $urandom_range(0, 2) == 0) begin
        p = 1;
        set_req(m, 1'b1, 1'($urandom_range(0, 1)),
                32'h800 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)));
      end
      if (m == 0) pend0 = p; else pend1 = p;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          m;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    int          exp_lat;
    int          exp_nwe;
  } vec_t;

  vec_t tbl [6];

  // ---------------- main test ----------------
  initial begin
    int gc, rc, nwe;
    logic [31:0] rd, a1;
    int gm[$], gcs[$];
    int t;

    tbl[0] = '{0, 1'b0, 32'h102, 32'h0,        4'b0000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0};
    tbl[1] = '{1, 1'b1, 32'h200, 32'h0000AA00, 4'b0010, 32'h11223344, 32'h0,        32'h1122AA44, 3, 1};
    tbl[2] = '{0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'b0000, 32'h12345678, 32'h0,        32'h12345678, 2, 0};
    tbl[3] = '{1, 1'b0, 32'h10F, 32'h0,        4'b1111, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2, 0};
    tbl[4] = '{0, 1'b1, 32'h304, 32'hA5A5A5A5, 4'b1111, 32'h00000000, 32'h0,        32'hA5A5A5A5, 2, 1};
    tbl[5] = '{0, 1'b1, 32'h208, 32'hAABBCCDD, 4'b1001, 32'h01020304, 32'h0,        32'hAA0203DD, 3, 1};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("idle_after_reset");

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      preload(tbl[i].addr, tbl[i].pre);
      run_txn(tbl[i].m, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, gc, rc, rd, nwe, a1);
      chk($sformatf("vec%0d_latency", i), 32'(rc - gc), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_nwe", i), 32'(nwe), 32'(tbl[i].exp_nwe));
      chk($sformatf("vec%0d_addr_t1", i), a1, {tbl[i].addr[31:2], 2'b00});
      chk($sformatf("vec%0d_mem", i), mem[tbl[i].addr[11:2]], tbl[i].exp_mem);
    end

    // Read data holds across later writes to the same master
    @(posedge clk); @(negedge clk);
    chk("hold_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("hold_m1_rdata", m1_rdata, 32'hCAFEF00D);

    // Back-to-back: full write then read of the same word
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h300, 32'h55AA55AA, 4'hF);
    t = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m0_gnt) begin t = cyc; break; end
    end
    if (t < 0) note_timeout("b2b_gnt");
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    @(negedge clk);
    chk("b2b_we_t1", {31'd0, ram_we_o}, 32'd1);
    chk("b2b_wdata_t1", ram_wdata_o, 32'h55AA55AA);
    @(negedge clk);
    chk("b2b_wr_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("b2b_wr_rdata", m0_rdata, 32'd0);
    chk("b2b_rd_gnt", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    chk("b2b_no_rvalid_t3", {31'd0, m0_rvalid}, 32'd0);
    @(negedge clk);
    chk("b2b_rd_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("b2b_rd_rdata", m0_rdata, 32'h55AA55AA);

    // Contention: both masters hold read requests
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h10C, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m0_gnt) begin gm.push_back(0); gcs.push_back(cyc); end
      if (m1_gnt) begin gm.push_back(1); gcs.push_back(cyc); end
    end
    @(posedge clk); #1;
    idle_all();
    chk("contend_ngrants", 32'(gm.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gm.size()) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk($sformatf("contend_winner%0d", i), 32'(gm[i]), 32'd0);
`else
        chk($sformatf("contend_winner%0d", i), 32'(gm[i]), 32'(i % 2));
`endif
        chk($sformatf("contend_spacing%0d", i), 32'(gcs[i] - gcs[0]), 32'(2 * i));
      end
    end
    repeat (4) @(posedge clk);

    // Reset in the middle of a partial write
    preload(32'h500, 32'h0BADF00D);
    @(posedge clk); #1;
    set_req(1, 1'b1, 1'b1, 32'h500, 32'h00770000, 4'b0100);
    t = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m1_gnt) begin t = cyc; break; end
    end
    if (t < 0) note_timeout("rmw_rst_gnt");
    @(posedge clk); #1;
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_we_access", {31'd0, ram_we_o}, 32'd0);
    @(negedge clk);
    chk_quiet("rmw_rst");
    @(posedge clk); #1 rst = 1'b0;
    nwe = 0;
    rc = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ram_we_o) nwe++;
      if (m0_rvalid || m1_rvalid) rc++;
    end
    chk("rmw_rst_no_we", 32'(nwe), 32'd0);
    chk("rmw_rst_no_rvalid", 32'(rc), 32'd0);
    chk("rmw_rst_mem", mem[32'h500 >> 2], 32'h0BADF00D);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b0, 32'h10C, 32'h0, 4'h0);
    @(negedge clk);
    chk("rmw_rst_first_tie", {30'd0, m1_gnt, m0_gnt}, 32'b01);
    @(posedge clk); #1;
    idle_all();
    repeat (4) @(posedge clk);

    // Random traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v;
      v = $urandom;
      ref_mem[i] = v;
      preload(32'h800 + 32'(i) * 4, v);
    end
    do_reset();
    free_cyc = cyc;
    last_win = 1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      mon_cycle();
      @(posedge clk); #1;
      drive_rand(k < 590);
    end
    idle_all();
    pend0 = 0; pend1 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      mon_cycle();
      @(posedge clk); #1;
    end
    chk("rnd_q0_drained", 32'(due_q0.size()), 32'd0);
    chk("rnd_q1_drained", 32'(due_q1.size()), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rnd_mem%0d", i), mem[512 + i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
